// File: rtl/jtframe_sdram_ba0_arb.sv
// Round-robin arbiter sharing the SDRAM bank-0 read/write port among three requesters.
// The winning request is registered onto ba0_*; ack/rdy go back only to the granted requester.
module jtframe_sdram_ba0_arb #(
    parameter int unsigned AW = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,

    input  logic [AW-1:0] rq0_addr,
    input  logic          rq0_rd,
    input  logic          rq0_wr,
    input  logic [15:0]   rq0_din,
    input  logic [1:0]    rq0_din_m,
    output logic          rq0_ack,
    output logic          rq0_rdy,

    input  logic [AW-1:0] rq1_addr,
    input  logic          rq1_rd,
    input  logic          rq1_wr,
    input  logic [15:0]   rq1_din,
    input  logic [1:0]    rq1_din_m,
    output logic          rq1_ack,
    output logic          rq1_rdy,

    input  logic [AW-1:0] rq2_addr,
    input  logic          rq2_rd,
    input  logic          rq2_wr,
    input  logic [15:0]   rq2_din,
    input  logic [1:0]    rq2_din_m,
    output logic          rq2_ack,
    output logic          rq2_rdy,

    output logic [AW-1:0] ba0_addr,
    output logic          ba0_rd,
    output logic          ba0_wr,
    output logic [15:0]   ba0_din,
    output logic [1:0]    ba0_din_m,
    input  logic          ba0_ack,
    input  logic          ba0_rdy,

    output logic [1:0]    gnt,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    sel, sel_nxt;
    logic [1:0]    last, last_nxt;
    logic [1:0]    gnt_nxt;
    logic [AW-1:0] addr_nxt;
    logic          rd_nxt, wr_nxt;
    logic [15:0]   din_nxt;
    logic [1:0]    din_m_nxt;

    logic [2:0]    req;
    logic [1:0]    pick;
    logic          pick_vld;
    logic [1:0]    src;
    logic [AW-1:0] m_addr;
    logic          m_rd, m_wr;
    logic [15:0]   m_din;
    logic [1:0]    m_din_m;
    logic          ack_fwd, rdy_fwd;

    assign req = {rq2_rd | rq2_wr, rq1_rd | rq1_wr, rq0_rd | rq0_wr};

    // Cyclic search starting just after the last granted index
    always_comb begin
        pick     = 2'd0;
        pick_vld = 1'b1;
        case (last)
            2'd0: begin
                if      (req[1]) pick = 2'd1;
                else if (req[2]) pick = 2'd2;
                else if (req[0]) pick = 2'd0;
                else             pick_vld = 1'b0;
            end
            2'd1: begin
                if      (req[2]) pick = 2'd2;
                else if (req[0]) pick = 2'd0;
                else if (req[1]) pick = 2'd1;
                else             pick_vld = 1'b0;
            end
            default: begin
                if      (req[0]) pick = 2'd0;
                else if (req[1]) pick = 2'd1;
                else if (req[2]) pick = 2'd2;
                else             pick_vld = 1'b0;
            end
        endcase
    end

    // In IDLE the candidate is the pick; otherwise it is the granted requester
    assign src = (state == ST_IDLE) ? pick : sel;

    always_comb begin
        case (src)
            2'd0: begin
                m_addr = rq0_addr; m_rd = rq0_rd; m_wr = rq0_wr;
                m_din  = rq0_din;  m_din_m = rq0_din_m;
            end
            2'd1: begin
                m_addr = rq1_addr; m_rd = rq1_rd; m_wr = rq1_wr;
                m_din  = rq1_din;  m_din_m = rq1_din_m;
            end
            default: begin
                m_addr = rq2_addr; m_rd = rq2_rd; m_wr = rq2_wr;
                m_din  = rq2_din;  m_din_m = rq2_din_m;
            end
        endcase
    end

    // Next-state and registered bank-0 port values
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        last_nxt  = last;
        gnt_nxt   = gnt;
        addr_nxt  = ba0_addr;
        rd_nxt    = ba0_rd;
        wr_nxt    = ba0_wr;
        din_nxt   = ba0_din;
        din_m_nxt = ba0_din_m;
        case (state)
            ST_IDLE: begin
                if (pick_vld && !hold) begin
                    sel_nxt   = pick;
                    last_nxt  = pick;
                    gnt_nxt   = pick;
                    addr_nxt  = m_addr;
                    rd_nxt    = m_rd & ~m_wr;
                    wr_nxt    = m_wr;
                    din_nxt   = m_din;
                    din_m_nxt = m_din_m;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (ba0_ack) begin
                    if (ba0_rdy) begin
                        rd_nxt    = 1'b0;
                        wr_nxt    = 1'b0;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end else if (!m_rd && !m_wr) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    state_nxt = ST_IDLE;
                end else begin
                    addr_nxt  = m_addr;
                    rd_nxt    = m_rd & ~m_wr;
                    wr_nxt    = m_wr;
                    din_nxt   = m_din;
                    din_m_nxt = m_din_m;
                end
            end
            ST_WAIT: begin
                if (ba0_rdy) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                rd_nxt    = 1'b0;
                wr_nxt    = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sel       <= 2'd0;
            last      <= 2'd2;
            gnt       <= 2'd3;
            busy      <= 1'b0;
            ba0_addr  <= '0;
            ba0_rd    <= 1'b0;
            ba0_wr    <= 1'b0;
            ba0_din   <= 16'd0;
            ba0_din_m <= 2'd0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            last      <= last_nxt;
            gnt       <= gnt_nxt;
            busy      <= (state_nxt != ST_IDLE);
            ba0_addr  <= addr_nxt;
            ba0_rd    <= rd_nxt;
            ba0_wr    <= wr_nxt;
            ba0_din   <= din_nxt;
            ba0_din_m <= din_m_nxt;
        end
    end

    // Zero-latency strobe return; rdy in GRANT only counts alongside its ack
    assign ack_fwd = !rst && (state == ST_GRANT) && ba0_ack;
    assign rdy_fwd = !rst && ba0_rdy &&
                     ((state == ST_WAIT) || ((state == ST_GRANT) && ba0_ack));

    assign rq0_ack = ack_fwd && (sel == 2'd0);
    assign rq1_ack = ack_fwd && (sel == 2'd1);
    assign rq2_ack = ack_fwd && (sel == 2'd2);
    assign rq0_rdy = rdy_fwd && (sel == 2'd0);
    assign rq1_rdy = rdy_fwd && (sel == 2'd1);
    assign rq2_rdy = rdy_fwd && (sel == 2'd2);

endmodule

// File: tb/tb_jtframe_sdram_ba0_arb.sv
// Directed bench for jtframe_sdram_ba0_arb: single access, round-robin order,
// write precedence, withdrawal, hold and reset during a transaction.
module tb_jtframe_sdram_ba0_arb;
    localparam int unsigned AW = 22;

    logic          clk = 1'b0;
    logic          rst, hold;
    logic [AW-1:0] addr [3];
    logic [2:0]    rd, wr;
    logic [15:0]   din [3];
    logic [1:0]    din_m [3];
    logic          rq0_ack, rq1_ack, rq2_ack, rq0_rdy, rq1_rdy, rq2_rdy;
    logic [AW-1:0] ba0_addr;
    logic          ba0_rd, ba0_wr, ba0_ack, ba0_rdy;
    logic [15:0]   ba0_din;
    logic [1:0]    ba0_din_m;
    logic [1:0]    gnt;
    logic          busy;
    logic [2:0]    ackv, rdyv;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign ackv = {rq2_ack, rq1_ack, rq0_ack};
    assign rdyv = {rq2_rdy, rq1_rdy, rq0_rdy};

    jtframe_sdram_ba0_arb #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .rq0_addr(addr[0]), .rq0_rd(rd[0]), .rq0_wr(wr[0]), .rq0_din(din[0]),
        .rq0_din_m(din_m[0]), .rq0_ack(rq0_ack), .rq0_rdy(rq0_rdy),
        .rq1_addr(addr[1]), .rq1_rd(rd[1]), .rq1_wr(wr[1]), .rq1_din(din[1]),
        .rq1_din_m(din_m[1]), .rq1_ack(rq1_ack), .rq1_rdy(rq1_rdy),
        .rq2_addr(addr[2]), .rq2_rd(rd[2]), .rq2_wr(wr[2]), .rq2_din(din[2]),
        .rq2_din_m(din_m[2]), .rq2_ack(rq2_ack), .rq2_rdy(rq2_rdy),
        .ba0_addr(ba0_addr), .ba0_rd(ba0_rd), .ba0_wr(ba0_wr), .ba0_din(ba0_din),
        .ba0_din_m(ba0_din_m), .ba0_ack(ba0_ack), .ba0_rdy(ba0_rdy),
        .gnt(gnt), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then observed 2 time units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; rd = 3'b000; wr = 3'b000;
        ba0_ack = 1'b0; ba0_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = AW'(32'h100 * (i + 1)); din[i] = 16'(i); din_m[i] = 2'b11;
        end
        tick(); tick();
        rst = 1'b0;
        chk("rst_rd",   32'(ba0_rd),   32'd0);
        chk("rst_wr",   32'(ba0_wr),   32'd0);
        chk("rst_addr", 32'(ba0_addr), 32'd0);
        chk("rst_din",  32'(ba0_din),  32'd0);
        chk("rst_gnt",  32'(gnt),      32'd3);
        chk("rst_busy", 32'(busy),     32'd0);
        #1 chk("rst_strobes", 32'({ackv, rdyv}), 32'd0);

        // single read on requester 0
        rd[0] = 1'b1; addr[0] = AW'(32'h12345);
        tick();
        chk("rd_ba0_rd",   32'(ba0_rd),   32'd1);
        chk("rd_ba0_wr",   32'(ba0_wr),   32'd0);
        chk("rd_addr",     32'(ba0_addr), 32'h12345);
        chk("rd_gnt",      32'(gnt),      32'd0);
        chk("rd_busy",     32'(busy),     32'd1);
        #1 chk("rd_noack_early", 32'(ackv), 32'd0);
        tick();
        ba0_ack = 1'b1;
        #1 chk("rd_ack", 32'(ackv), 32'b001);
        chk("rd_ack_rdy", 32'(rdyv), 32'b000);
        tick();
        ba0_ack = 1'b0;
        #1 chk("rd_ack_once", 32'(ackv), 32'd0);
        chk("rd_wait_rd", 32'(ba0_rd), 32'd1);
        tick();
        #1 chk("rd_no_rdy_yet", 32'(rdyv), 32'd0);
        tick();
        ba0_rdy = 1'b1;
        #1 chk("rd_rdy", 32'(rdyv), 32'b001);
        chk("rd_rdy_ack", 32'(ackv), 32'b000);
        tick();
        ba0_rdy = 1'b0; rd[0] = 1'b0;
        chk("rd_done_rd",   32'(ba0_rd), 32'd0);
        chk("rd_done_busy", 32'(busy),   32'd0);
        chk("rd_done_gnt",  32'(gnt),    32'd0);
        #1 chk("rd_done_rdy", 32'(rdyv), 32'd0);

        // round-robin from a fresh reset: order 0,1,2,0,1,2
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) addr[i] = AW'(32'h2000 + i);
        rd = 3'b111;
        for (int i = 0; i < 6; i++) begin
            tick();
            rd = 3'b111;
            chk("rr_gnt",  32'(gnt),      32'(i % 3));
            chk("rr_addr", 32'(ba0_addr), 32'h2000 + 32'(i % 3));
            chk("rr_rd",   32'(ba0_rd),   32'd1);
            ba0_ack = 1'b1;
            #1 chk("rr_ack", 32'(ackv), 32'(1 << (i % 3)));
            tick();
            ba0_ack = 1'b0; ba0_rdy = 1'b1;
            #1 chk("rr_rdy", 32'(rdyv), 32'(1 << (i % 3)));
            tick();
            ba0_rdy = 1'b0; rd[i % 3] = 1'b0;
            chk("rr_idle_rd", 32'(ba0_rd), 32'd0);
        end
        rd = 3'b000;
        tick();
        chk("rr_end_busy", 32'(busy), 32'd0);

        // write precedence on requester 1 with ack and rdy together
        rd[1] = 1'b1; wr[1] = 1'b1; din[1] = 16'hBEEF; din_m[1] = 2'b01; addr[1] = AW'(32'h3F0F0);
        tick();
        chk("wr_gnt",   32'(gnt),       32'd1);
        chk("wr_wr",    32'(ba0_wr),    32'd1);
        chk("wr_rd",    32'(ba0_rd),    32'd0);
        chk("wr_din",   32'(ba0_din),   32'hBEEF);
        chk("wr_din_m", 32'(ba0_din_m), 32'b01);
        chk("wr_addr",  32'(ba0_addr),  32'h3F0F0);
        ba0_ack = 1'b1; ba0_rdy = 1'b1;
        #1 chk("wr_ack", 32'(ackv), 32'b010);
        chk("wr_rdy", 32'(rdyv), 32'b010);
        tick();
        ba0_ack = 1'b0; ba0_rdy = 1'b0; rd[1] = 1'b0; wr[1] = 1'b0;
        chk("wr_done_busy", 32'(busy),   32'd0);
        chk("wr_done_wr",   32'(ba0_wr), 32'd0);

        // withdrawal before ack on requester 2
        rd[2] = 1'b1;
        tick();
        chk("wd_gnt", 32'(gnt),    32'd2);
        chk("wd_rd",  32'(ba0_rd), 32'd1);
        rd[2] = 1'b0;
        #1 chk("wd_noack", 32'(ackv), 32'd0);
        tick();
        chk("wd_idle_rd",   32'(ba0_rd), 32'd0);
        chk("wd_idle_busy", 32'(busy),   32'd0);
        ba0_ack = 1'b1; ba0_rdy = 1'b1;
        #1 chk("wd_stray", 32'({ackv, rdyv}), 32'd0);
        ba0_ack = 1'b0; ba0_rdy = 1'b0;

        // drop after ack: transaction still completes
        rd[2] = 1'b1;
        tick();
        chk("cm_gnt", 32'(gnt), 32'd2);
        ba0_ack = 1'b1;
        #1 chk("cm_ack", 32'(ackv), 32'b100);
        tick();
        ba0_ack = 1'b0; rd[2] = 1'b0;
        tick();
        chk("cm_rd_held", 32'(ba0_rd), 32'd1);
        chk("cm_busy",    32'(busy),   32'd1);
        ba0_rdy = 1'b1;
        #1 chk("cm_rdy", 32'(rdyv), 32'b100);
        tick();
        ba0_rdy = 1'b0;
        chk("cm_done_rd", 32'(ba0_rd), 32'd0);

        // hold blocks new grants but not an in-flight one
        hold = 1'b1; rd[0] = 1'b1; addr[0] = AW'(32'h55);
        tick(); tick();
        chk("hold_busy", 32'(busy),   32'd0);
        chk("hold_rd",   32'(ba0_rd), 32'd0);
        hold = 1'b0;
        tick();
        chk("hold_rel_gnt", 32'(gnt),    32'd0);
        chk("hold_rel_rd",  32'(ba0_rd), 32'd1);
        ba0_ack = 1'b1;
        tick();
        ba0_ack = 1'b0; hold = 1'b1;
        tick();
        chk("hold_wait_busy", 32'(busy), 32'd1);
        ba0_rdy = 1'b1;
        #1 chk("hold_wait_rdy", 32'(rdyv), 32'b001);
        tick();
        ba0_rdy = 1'b0; rd[0] = 1'b0; rd[1] = 1'b1;
        tick(); tick();
        chk("hold_block_busy", 32'(busy),   32'd0);
        chk("hold_block_rd",   32'(ba0_rd), 32'd0);
        hold = 1'b0;
        tick();
        chk("hold_next_gnt", 32'(gnt),  32'd1);
        chk("hold_next_busy", 32'(busy), 32'd1);

        // reset during WAIT
        ba0_ack = 1'b1;
        tick();
        ba0_ack = 1'b0; rst = 1'b1; ba0_rdy = 1'b1;
        #1 chk("rst_mid_fwd", 32'(rdyv), 32'd0);
        tick();
        rst = 1'b0;
        chk("rst_mid_rd",   32'(ba0_rd), 32'd0);
        chk("rst_mid_gnt",  32'(gnt),    32'd3);
        chk("rst_mid_busy", 32'(busy),   32'd0);
        #1 chk("rst_late_rdy", 32'(rdyv), 32'd0);
        ba0_rdy = 1'b0; rd = 3'b011;
        tick();
        chk("rst_next_gnt", 32'(gnt), 32'd0);
        rd = 3'b000;
        tick();
        chk("rst_next_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
